regfile_sequencer: RTL and testbench

- Control-side counterpart of the 8-entry register file: consumes an instruction byte stream and drives the register file's enab/mux_sel/seg controls and OR2 operand.
- Sits between instruction fetch and the register file/ALU; turns each instruction into a fixed, cycle-exact control sequence.
- Multi-cycle ops (immediate load, ALU round trip) are sequenced by an FSM with a latency counter.

---
 rtl/regfile_sequencer_if.sv | 30 +++
 rtl/regfile_sequencer.sv | 178 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Instruction-stream and register-file control bundle for regfile_sequencer.
// Handshake: a byte transfers on the rising clk edge where instr_valid and
// instr_ready are both high. instr_data is ignored at any other time. The
// producer may raise instr_valid without waiting for instr_ready. The producer
// must hold instr_valid and instr_data stable until that transfer edge.
interface regfile_sequencer_if;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [1:0] enab;
    logic [1:0] mux_sel;
    logic [2:0] seg;
    logic [7:0] or2_out;
    logic       alu_start;
    logic       done;
    logic       illegal;
    logic       busy;

    // Instruction fetch side: supplies bytes and observes the control outputs.
    modport master (
        output instr_valid, instr_data,
        input  instr_ready, enab, mux_sel, seg, or2_out, alu_start, done, illegal, busy
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr_data,
        output instr_ready, enab, mux_sel, seg, or2_out, alu_start, done, illegal, busy
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Turns instruction bytes into cycle-exact register-file control sequences.
// Every output is registered. The next-cycle values are computed from the
// next state, so control lines and the state change on the same clk edge.
module regfile_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_sequencer_if.slave bus,
    output logic [2:0]         dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IMM = 3'd1,
        WRITE    = 3'd2,
        CLEAR    = 3'd3,
        READ     = 3'd4,
        ALU_WAIT = 3'd5,
        ALU_WB   = 3'd6,
        FLAG     = 3'd7
    } state_t;

    // Preload for the wait counter. The counter stops at zero, which gives ALU_LAT wait cycles.
    localparam logic [3:0] LAT_M1 = (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);

    localparam logic [1:0] EN_CLEAR = 2'b00;
    localparam logic [1:0] EN_WRITE = 2'b01;
    localparam logic [1:0] EN_IDLE  = 2'b10;
    localparam logic [1:0] EN_READ  = 2'b11;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] n_reg, n_nx;
    logic [1:0] enab_nx, mux_nx;
    logic [2:0] seg_nx;
    logic [7:0] or2_nx;
    logic       alu_start_nx, done_nx, illegal_nx, ready_nx, busy_nx;

    logic       accept;
    logic [2:0] op;
    logic [2:0] n_in;

    assign accept    = bus.instr_valid & bus.instr_ready;
    assign op        = bus.instr_data[7:5];
    assign n_in      = bus.instr_data[2:0];
    assign dbg_state = state;

    // Bits [4:3] of the instruction byte carry no meaning.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.instr_data[4:3]};

    // Next state and next-cycle control values.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        n_nx         = n_reg;
        enab_nx      = EN_IDLE;
        mux_nx       = bus.mux_sel;
        seg_nx       = bus.seg;
        or2_nx       = bus.or2_out;
        alu_start_nx = 1'b0;
        done_nx      = 1'b0;
        illegal_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        3'b000: begin
                            state_nx = FLAG;
                            done_nx  = 1'b1;
                        end
                        3'b001, 3'b010: begin
                            state_nx = WRITE;
                            enab_nx  = EN_WRITE;
                            mux_nx   = (op == 3'b001) ? 2'b00 : 2'b01;
                            seg_nx   = n_in;
                            done_nx  = 1'b1;
                        end
                        3'b011: begin
                            state_nx = WAIT_IMM;
                            n_nx     = n_in;
                        end
                        3'b100: begin
                            state_nx     = READ;
                            enab_nx      = EN_READ;
                            seg_nx       = n_in;
                            alu_start_nx = 1'b1;
                        end
                        3'b101: begin
                            state_nx = CLEAR;
                            enab_nx  = EN_CLEAR;
                            seg_nx   = 3'b000;
                            done_nx  = 1'b1;
                        end
                        default: begin
                            state_nx   = FLAG;
                            illegal_nx = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_IMM: begin
                if (accept) begin
                    state_nx = WRITE;
                    or2_nx   = bus.instr_data;
                    enab_nx  = EN_WRITE;
                    mux_nx   = 2'b10;
                    seg_nx   = n_reg;
                    done_nx  = 1'b1;
                end
            end
            READ: begin
                if (ALU_LAT == 0) begin
                    state_nx = ALU_WB;
                    enab_nx  = EN_WRITE;
                    mux_nx   = 2'b11;
                    seg_nx   = 3'b000;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ALU_WAIT;
                    cnt_nx   = LAT_M1;
                end
            end
            ALU_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ALU_WB;
                    enab_nx  = EN_WRITE;
                    mux_nx   = 2'b11;
                    seg_nx   = 3'b000;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WRITE, CLEAR, ALU_WB, FLAG: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        ready_nx = (state_nx == IDLE) || (state_nx == WAIT_IMM);
        busy_nx  = (state_nx != IDLE);
    end

    // State and registered outputs. Reset discards any pending operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            n_reg           <= 3'd0;
            bus.enab        <= EN_IDLE;
            bus.mux_sel     <= 2'b00;
            bus.seg         <= 3'b000;
            bus.or2_out     <= 8'h00;
            bus.alu_start   <= 1'b0;
            bus.done        <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.instr_ready <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            n_reg           <= n_nx;
            bus.enab        <= enab_nx;
            bus.mux_sel     <= mux_nx;
            bus.seg         <= seg_nx;
            bus.or2_out     <= or2_nx;
            bus.alu_start   <= alu_start_nx;
            bus.done        <= done_nx;
            bus.illegal     <= illegal_nx;
            bus.busy        <= busy_nx;
            bus.instr_ready <= ready_nx;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer. The main instance uses ALU_LAT=3 and a second instance uses ALU_LAT=0.
// Expected completions are queued when an instruction is accepted. They are
// compared when done or illegal pulses.
module tb_regfile_sequencer;
    localparam int LAT = 3;
    localparam int W   = 25;  // {enab,mux_sel,seg,or2_out,done,illegal} + 8-bit latency

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_sequencer_if b3 ();
    regfile_sequencer_if b0 ();
    logic [2:0] dbg3, dbg0;

    regfile_sequencer #(.ALU_LAT(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b3),
        .dbg_state (dbg3)
    );

    regfile_sequencer #(.ALU_LAT(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b0),
        .dbg_state (dbg0)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic [4:0]   rd_q[$];
    int           rdt_q[$];

    // Bench-side model of held control values.
    logic [1:0] m_mux = 2'b00;
    logic [2:0] m_seg = 3'b000;
    logic [7:0] m_or2 = 8'h00;
    logic       post_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [1:0] en, input logic [1:0] mx,
                                          input logic [2:0] sg, input logic [7:0] o2,
                                          input logic dn, input logic il, input int lat);
        return {en, mx, sg, o2, dn, il, 8'(lat)};
    endfunction

    // Drive one byte and wait for its transfer. t returns the index of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int t);
        int budget;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        b3.instr_valid = 1'b1;
        b3.instr_data  = b;
        budget = 100;
        while (!b3.instr_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", 0, 1);
        t = cyc + 1;
        @(posedge clk);
        #1;
        b3.instr_valid = 1'b0;
        b3.instr_data  = 8'($urandom);
    endtask

    // Issue one instruction and queue its expected completion.
    task automatic do_instr(input logic [7:0] b, input logic [7:0] imm, input int gap, input int imm_gap);
        int t;
        logic [2:0] op, n;
        op = b[7:5];
        n  = b[2:0];
        send_byte(b, gap, t);
        case (op)
            3'd0: begin
                exp_q.push_back(pack(2'b10, m_mux, m_seg, m_or2, 1'b1, 1'b0, 1));
                acc_q.push_back(t);
            end
            3'd1, 3'd2: begin
                m_mux = (op == 3'd1) ? 2'b00 : 2'b01;
                m_seg = n;
                exp_q.push_back(pack(2'b01, m_mux, m_seg, m_or2, 1'b1, 1'b0, 1));
                acc_q.push_back(t);
            end
            3'd3: begin
                repeat (imm_gap) begin
                    @(negedge clk);
                    check("imm_gap_ready", b3.instr_ready, 1);
                    check("imm_gap_busy", b3.busy, 1);
                end
                send_byte(imm, 0, t);
                m_or2 = imm;
                m_mux = 2'b10;
                m_seg = n;
                exp_q.push_back(pack(2'b01, m_mux, m_seg, m_or2, 1'b1, 1'b0, 1));
                acc_q.push_back(t);
            end
            3'd4: begin
                rd_q.push_back({2'b11, n});
                rdt_q.push_back(t);
                m_mux = 2'b11;
                m_seg = 3'b000;
                exp_q.push_back(pack(2'b01, m_mux, m_seg, m_or2, 1'b1, 1'b0, 2 + LAT));
                acc_q.push_back(t);
            end
            3'd5: begin
                m_seg = 3'b000;
                exp_q.push_back(pack(2'b00, m_mux, m_seg, m_or2, 1'b1, 1'b0, 1));
                acc_q.push_back(t);
            end
            default: begin
                exp_q.push_back(pack(2'b10, m_mux, m_seg, m_or2, 1'b0, 1'b1, 1));
                acc_q.push_back(t);
            end
        endcase
    endtask

    task automatic drain();
        int budget = 60;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        check("drain_exp_q", exp_q.size(), 0);
        check("drain_rd_q", rd_q.size(), 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_enab"}, b3.enab, 2'b10);
        check({pfx, "_mux_seg"}, {b3.mux_sel, b3.seg}, 5'b0);
        check({pfx, "_or2"}, b3.or2_out, 8'h00);
        check({pfx, "_pulses"}, {b3.alu_start, b3.done, b3.illegal}, 3'b000);
        check({pfx, "_busy_ready"}, {b3.busy, b3.instr_ready}, 2'b00);
        check({pfx, "_state"}, dbg3, 3'd0);
    endtask

    // Scoreboard monitor. It samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] w;
        logic [4:0]   r;
        int           t;
        if (!rst_n) begin
            post_done = 1'b0;
        end else begin
            if (post_done) begin
                check("post_done_ready", b3.instr_ready, 1);
                check("post_done_enab", b3.enab, 2'b10);
                check("post_done_busy", b3.busy, 0);
                post_done = 1'b0;
            end
            check("enab_only_in_ctrl_cycles", (b3.enab != 2'b10) && !(b3.done || b3.alu_start), 0);
            if (b3.alu_start) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_alu_start", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    t = rdt_q.pop_front();
                    check("read_cycle", {b3.enab, b3.seg, b3.busy}, {r, 1'b1});
                    check("read_latency", 32'(cyc - t + 1), 1);
                end
            end
            if (b3.done || b3.illegal) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("result", {b3.enab, b3.mux_sel, b3.seg, b3.or2_out, b3.done, b3.illegal}, 32'(w[W-1:8]));
                    check("latency", 32'(cyc - t + 1), 32'(w[7:0]));
                end
                post_done = 1'b1;
            end
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        int budget;
        logic [7:0] b;
        b3.instr_valid = 1'b0;
        b3.instr_data  = 8'h00;
        b0.instr_valid = 1'b0;
        b0.instr_data  = 8'h00;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("por");
        #2 rst_n = 1'b1;
        #1 check("ready_before_first_edge", b3.instr_ready, 0);
        @(negedge clk);
        check("ready_after_first_edge", b3.instr_ready, 1);

        // MOV R5,R0
        do_instr(8'h25, 8'h00, 0, 0);
        drain();
        // MVI R3 with a three-cycle gap before the immediate
        do_instr(8'h63, 8'hA7, 0, 3);
        drain();
        // ALU with R2, ALU_LAT=3
        do_instr(8'h82, 8'h00, 0, 0);
        drain();
        // CLEAR and then an illegal opcode
        do_instr(8'hA0, 8'h00, 0, 0);
        do_instr(8'hC4, 8'h00, 0, 0);
        drain();

        // Random instruction mix with random gaps
        for (int i = 0; i < 40; i++) begin
            b = {3'($urandom_range(0, 7)), 2'($urandom), 3'($urandom_range(0, 7))};
            do_instr(b, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        drain();

        // ALU_LAT=0: READ is followed directly by ALU_WB
        @(negedge clk);
        b0.instr_valid = 1'b1;
        b0.instr_data  = 8'h81;
        budget = 20;
        while (!b0.instr_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("lat0_accept_timeout", 0, 1);
        @(posedge clk);
        #1 b0.instr_valid = 1'b0;
        @(negedge clk);
        check("lat0_read", {b0.enab, b0.seg, b0.alu_start, b0.done}, {2'b11, 3'b001, 1'b1, 1'b0});
        @(negedge clk);
        check("lat0_wb", {b0.enab, b0.mux_sel, b0.seg, b0.done, b0.alu_start}, {2'b01, 2'b11, 3'b000, 1'b1, 1'b0});
        @(negedge clk);
        check("lat0_idle", {b0.enab, b0.instr_ready, b0.done, b0.busy}, {2'b10, 1'b1, 1'b0, 1'b0});

        // Reset asserted during ALU_WAIT
        do_instr(8'h85, 8'h00, 0, 0);
        @(negedge clk);  // READ cycle
        @(negedge clk);  // first wait cycle
        check("pre_reset_in_wait", {b3.enab, b3.busy, dbg3}, {2'b10, 1'b1, 3'd5});
        #2 rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        rd_q.delete();
        rdt_q.delete();
        m_mux = 2'b00;
        m_seg = 3'b000;
        m_or2 = 8'h00;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_ready", {b3.instr_ready, b3.busy, b3.enab}, {1'b1, 1'b0, 2'b10});

        // The sequencer must still operate normally after the reset.
        do_instr(8'h3F, 8'h00, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
